// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receive/transmit blocks.
package serial_pkg;

   // Receive FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } deser_state_t;

   // Word direction encodings, common to transmit and receive sides
   localparam logic DIR_LSB_FIRST = 1'b1;
   localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/deser_bit_counter.sv
// Modulo-N bit counter; wrap_c strobes on the bit that completes a word.
module deser_bit_counter #(
   parameter  int unsigned N  = 8,
   localparam int unsigned CW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          wrap_c
);

   logic [CW-1:0] count_q;

   // Terminal count reached on an accepted bit (clear suppresses it)
   assign wrap_c = en && !clr && (count_q == CW'(N - 1));
   assign count  = count_q;

   // Count accepted bits, wrapping to zero at N
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         if (wrap_c) begin
            count_q <= '0;
         end else begin
            count_q <= count_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in / parallel-out receiver with a valid/ready holding register.
module serial_deserializer #(
   parameter  int unsigned N  = 8,
   localparam int unsigned CW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          serial_in,
   input  logic          bit_valid,
   input  logic          right_shift,
   input  logic          clear,
   input  logic          data_ready,
   output logic [N-1:0]  data_out,
   output logic          data_valid,
   output logic          overrun,
   output logic          busy,
   output logic [CW-1:0] bit_count
);

   import serial_pkg::*;

   deser_state_t  state_q, state_d;
   logic          dir_q, dir_d;
   logic [N-1:0]  sreg_q, sreg_d;
   logic [N-1:0]  word_c;
   logic          wrap_c;

   deser_bit_counter #(.N(N)) u_bit_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (bit_valid),
      .clr     (clear),
      .count   (bit_count),
      .wrap_c  (wrap_c)
   );

   // Next state, direction latch and shift register update
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      sreg_d  = sreg_q;
      word_c  = sreg_q;
      if (clear) begin
         state_d = IDLE;
         sreg_d  = '0;
      end else if (bit_valid) begin
         // Direction is captured only on the first bit of a word
         if (state_q == IDLE) begin
            dir_d = right_shift;
         end
         if (dir_d == DIR_LSB_FIRST) begin
            word_c = {serial_in, sreg_q[N-1:1]};
         end else begin
            word_c = {sreg_q[N-2:0], serial_in};
         end
         sreg_d  = word_c;
         state_d = wrap_c ? IDLE : SHIFT;
      end
   end

   // State, datapath and handshake registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         dir_q      <= DIR_MSB_FIRST;
         sreg_q     <= '0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         sreg_q  <= sreg_d;
         busy    <= (state_d == SHIFT);
         overrun <= 1'b0;
         if (wrap_c) begin
            // Completed word loads only if the holding register is free this edge
            if (!data_valid || data_ready) begin
               data_out   <= word_c;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule
